pc_sequencer: RTL and testbench

Multi-cycle control FSM that drives the program counter's advance and jump inputs. It sits between the instruction decoder and the PC. It holds each instruction for its execute and memory latency, then issues exactly one commit pulse per instruction. That pulse carries the PC advance, the absolute-jump select and the jump target. The block also keeps saturating cycle and retired-instruction counters for the test harness.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_sequencer_sat_counter.sv | 24 ++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the program-counter sequencer.
// The latched decode payload is sized by PC_W, so the top's D must match it.
package pc_seq_pkg;

    localparam int unsigned PC_W  = 12;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_MEMWAIT = 3'd3,
        S_COMMIT  = 3'd4,
        S_HALT    = 3'd5
    } pc_seq_state_t;

    typedef struct packed {
        logic            taken;
        logic            mem;
        logic [PC_W-1:0] target;
    } dec_latch_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: holds each instruction for its execute/memory
// latency, then issues one commit pulse carrying PC advance and jump target.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D  = PC_W,
    parameter int unsigned CW = CNT_W,
    parameter int unsigned LW = LAT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dec_halt,
    input  logic          dec_jump,
    input  logic          dec_branch,
    input  logic          dec_mem,
    input  logic [LW-1:0] dec_lat,
    input  logic [D-1:0]  br_target,
    input  logic          flag_zero,
    input  logic          mem_done,
    output logic          next_flag,
    output logic          absjump_en,
    output logic [D-1:0]  target,
    output logic          reg_we,
    output logic          mem_req,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] instr_count
);

    pc_seq_state_t state;
    dec_latch_t    lat_q;
    dec_latch_t    fetch_lat;
    dec_latch_t    commit_src;
    logic [LW-1:0] lat_cnt;

    assign fetch_lat.taken  = dec_jump | (dec_branch & flag_zero);
    assign fetch_lat.mem    = dec_mem;
    assign fetch_lat.target = PC_W'(br_target);

    // A zero-latency instruction commits straight out of FETCH, before lat_q is loaded.
    assign commit_src = (state == S_FETCH) ? fetch_lat : lat_q;

    // Outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            lat_q      <= '0;
            lat_cnt    <= '0;
            next_flag  <= 1'b0;
            reg_we     <= 1'b0;
            absjump_en <= 1'b0;
            target     <= '0;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            next_flag  <= 1'b0;
            reg_we     <= 1'b0;
            absjump_en <= 1'b0;
            target     <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    lat_q   <= fetch_lat;
                    lat_cnt <= dec_lat;
                    if (dec_halt) begin
                        state <= S_HALT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (dec_lat != '0) begin
                        state <= S_EXEC;
                    end else if (dec_mem) begin
                        state   <= S_MEMWAIT;
                        mem_req <= 1'b1;
                    end else begin
                        state      <= S_COMMIT;
                        next_flag  <= 1'b1;
                        reg_we     <= 1'b1;
                        absjump_en <= commit_src.taken;
                        target     <= commit_src.taken ? D'(commit_src.target) : '0;
                    end
                end
                S_EXEC: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) begin
                        if (lat_q.mem) begin
                            state   <= S_MEMWAIT;
                            mem_req <= 1'b1;
                        end else begin
                            state      <= S_COMMIT;
                            next_flag  <= 1'b1;
                            reg_we     <= 1'b1;
                            absjump_en <= commit_src.taken;
                            target     <= commit_src.taken ? D'(commit_src.target) : '0;
                        end
                    end
                end
                S_MEMWAIT: begin
                    if (mem_done) begin
                        state      <= S_COMMIT;
                        mem_req    <= 1'b0;
                        next_flag  <= 1'b1;
                        reg_we     <= 1'b1;
                        absjump_en <= commit_src.taken;
                        target     <= commit_src.taken ? D'(commit_src.target) : '0;
                    end
                end
                S_COMMIT: begin
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CW)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (busy),
        .clr   (1'b0),
        .q     (cycle_count)
    );

    sat_counter #(.W(CW)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (next_flag),
        .clr   (1'b0),
        .q     (instr_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with 4-bit counters so saturation is reachable.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        dec_halt;
    logic        dec_jump;
    logic        dec_branch;
    logic        dec_mem;
    logic [2:0]  dec_lat;
    logic [11:0] br_target;
    logic        flag_zero;
    logic        mem_done;
    logic        next_flag;
    logic        absjump_en;
    logic [11:0] target;
    logic        reg_we;
    logic        mem_req;
    logic        busy;
    logic        done;
    logic [3:0]  cycle_count;
    logic [3:0]  instr_count;

    int vectors = 0;
    int errors  = 0;
    int pulses;

    always #5 clk = ~clk;

    pc_sequencer #(.D(12), .CW(4), .LW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dec_halt    (dec_halt),
        .dec_jump    (dec_jump),
        .dec_branch  (dec_branch),
        .dec_mem     (dec_mem),
        .dec_lat     (dec_lat),
        .br_target   (br_target),
        .flag_zero   (flag_zero),
        .mem_done    (mem_done),
        .next_flag   (next_flag),
        .absjump_en  (absjump_en),
        .target      (target),
        .reg_we      (reg_we),
        .mem_req     (mem_req),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_dec();
        dec_halt   = 1'b0;
        dec_jump   = 1'b0;
        dec_branch = 1'b0;
        dec_mem    = 1'b0;
        dec_lat    = 3'd0;
        br_target  = 12'h000;
        flag_zero  = 1'b0;
        mem_done   = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 1 (FETCH of the first instruction).
    task automatic reset_and_start();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        clear_dec();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".outs"}, 32'({next_flag, absjump_en, reg_we, mem_req, busy, done}), 32'd0);
        chk({tag, ".target"}, 32'(target), 32'd0);
        chk({tag, ".cycles"}, 32'(cycle_count), 32'd0);
        chk({tag, ".instrs"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        clear_dec();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Four plain instructions, then halt on the fifth fetch.
        reset_and_start();
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("plain.next_flag.c%0d", c), 32'(next_flag), 32'(c % 2 == 0));
            chk($sformatf("plain.reg_we.c%0d", c), 32'(reg_we), 32'(c % 2 == 0));
            chk($sformatf("plain.absjump.c%0d", c), 32'(absjump_en), 32'd0);
        end
        @(negedge clk);
        chk("plain.instr_count", 32'(instr_count), 32'd4);
        chk("plain.cycle_count", 32'(cycle_count), 32'd8);
        chk("plain.busy", 32'(busy), 32'd1);
        dec_halt = 1'b1;
        @(negedge clk);
        dec_halt = 1'b0;
        chk("halt.done", 32'(done), 32'd1);
        chk("halt.busy", 32'(busy), 32'd0);
        chk("halt.next_flag", 32'(next_flag), 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            start = (c % 2 == 0);
            @(negedge clk);
            pulses += int'(next_flag);
        end
        start = 1'b0;
        chk("halt.no_commit", 32'(pulses), 32'd0);
        chk("halt.done_sticky", 32'(done), 32'd1);
        chk("halt.cycles_frozen", 32'(cycle_count), 32'd9);
        chk("halt.instrs_frozen", 32'(instr_count), 32'd4);

        // Taken branch with one execute cycle; flag and target change in EXEC.
        reset_and_start();
        dec_branch = 1'b1;
        br_target  = 12'h0A5;
        flag_zero  = 1'b1;
        dec_lat    = 3'd1;
        @(negedge clk);
        chk("br_taken.exec_next_flag", 32'(next_flag), 32'd0);
        chk("br_taken.exec_target", 32'(target), 32'd0);
        flag_zero = 1'b0;
        br_target = 12'h123;
        @(negedge clk);
        chk("br_taken.next_flag", 32'(next_flag), 32'd1);
        chk("br_taken.absjump", 32'(absjump_en), 32'd1);
        chk("br_taken.target", 32'(target), 32'h0A5);
        // Not-taken branch, flag raised only after fetch.
        @(negedge clk);
        br_target = 12'h0A5;
        flag_zero = 1'b0;
        @(negedge clk);
        flag_zero = 1'b1;
        @(negedge clk);
        chk("br_not.next_flag", 32'(next_flag), 32'd1);
        chk("br_not.absjump", 32'(absjump_en), 32'd0);
        chk("br_not.target", 32'(target), 32'd0);
        @(negedge clk);
        chk("br.instr_count", 32'(instr_count), 32'd2);
        chk("br.cycle_count", 32'(cycle_count), 32'd6);

        // Latency 3 plus memory with completion on the second MEMWAIT cycle.
        reset_and_start();
        dec_lat = 3'd3;
        dec_mem = 1'b1;
        pulses  = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin
                dec_lat = 3'd0;
                dec_mem = 1'b0;
            end
            mem_done = (c == 6);
            chk($sformatf("mem.mem_req.c%0d", c), 32'(mem_req), 32'(c == 5 || c == 6));
            chk($sformatf("mem.next_flag.c%0d", c), 32'(next_flag), 32'(c == 7));
            pulses += int'(next_flag);
        end
        mem_done = 1'b0;
        @(negedge clk);
        chk("mem.pulses", 32'(pulses), 32'd1);
        chk("mem.instr_count", 32'(instr_count), 32'd1);
        chk("mem.cycle_count", 32'(cycle_count), 32'd7);
        chk("mem.busy_fetch", 32'(busy), 32'd1);

        // Asynchronous reset in the middle of EXEC.
        reset_and_start();
        dec_lat = 3'd3;
        @(negedge clk);
        chk("areset.busy_before", 32'(busy), 32'd1);
        chk("areset.cycles_before", 32'(cycle_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("areset");
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += int'(reg_we);
        end
        chk("areset.no_reg_we", 32'(pulses), 32'd0);
        chk("areset.idle_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("areset.stays_idle", 32'(busy), 32'd0);

        // Saturation: 20 single-cycle-pair instructions into 4-bit counters.
        reset_and_start();
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            pulses += int'(next_flag);
            if (c == 16) chk("sat.cycles_at_max", 32'(cycle_count), 32'd15);
            if (c == 17) chk("sat.cycles_no_wrap", 32'(cycle_count), 32'd15);
            if (c == 31) chk("sat.instrs_at_max", 32'(instr_count), 32'd15);
        end
        @(negedge clk);
        chk("sat.pulses", 32'(pulses), 32'd20);
        chk("sat.cycle_count", 32'(cycle_count), 32'd15);
        chk("sat.instr_count", 32'(instr_count), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
